// File: rtl/spi_cmd_sequencer.sv
// spi_cmd_sequencer
// Buffers 32-bit command words, hands them one at a time to a downstream SPI
// engine with a timed level trigger, waits a settling gap, then captures the
// engine's deserialized word into a response FIFO.
//
// Ports
//   clk, rst              system clock, synchronous active-high reset
//   cmd_wr_en, cmd_din    command FIFO write side
//   cmd_full, cmd_empty   registered command FIFO flags
//   spi_din, spi_trigger  registered command word / trigger to the SPI engine
//   spi_dout              word returned by the SPI engine
//   rsp_rd_en, rsp_dout   response FIFO read side (first-word-fall-through)
//   rsp_empty             registered response FIFO flag
//   busy                  sequencer is not idle
//   overflow              sticky: a command write was dropped because full
module spi_cmd_sequencer #(
    parameter int DEPTH       = 8,
    parameter int TRIG_CYCLES = 1700,
    parameter int GAP_CYCLES  = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_wr_en,
    input  logic [31:0] cmd_din,
    output logic        cmd_full,
    output logic        cmd_empty,
    output logic [31:0] spi_din,
    output logic        spi_trigger,
    input  logic [31:0] spi_dout,
    input  logic        rsp_rd_en,
    output logic [31:0] rsp_dout,
    output logic        rsp_empty,
    output logic        busy,
    output logic        overflow
);

    localparam int AW   = $clog2(DEPTH);
    localparam int PW   = AW + 1;
    localparam int CMAX = (TRIG_CYCLES > GAP_CYCLES) ? TRIG_CYCLES : GAP_CYCLES;
    localparam int CW   = $clog2(CMAX + 1);

    // spi_trigger is registered from the state, so it trails the TRIG state by
    // one cycle. GAP therefore runs GAP_CYCLES+1 state cycles: the first one
    // still shows the trailing trigger, the remaining GAP_CYCLES show it low.
    localparam logic [CW-1:0] TRIG_LAST = CW'(TRIG_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYCLES);

    typedef enum logic [1:0] {IDLE, TRIG, GAP, CAPTURE} state_t;

    state_t        r_state, w_state_nxt;
    logic [CW-1:0] r_cnt, w_cnt_nxt;
    logic          w_cmd_pop, w_rsp_push;

    // ------------------------------------------------------------------
    // Command FIFO
    // ------------------------------------------------------------------
    logic [31:0]   r_cmd_mem [DEPTH];
    logic [PW-1:0] r_cmd_wptr, r_cmd_rptr;
    logic [PW-1:0] w_cmd_wptr_nxt, w_cmd_rptr_nxt;
    logic          r_cmd_full, r_cmd_empty, r_overflow;
    logic          w_cmd_push;

    assign w_cmd_push     = cmd_wr_en & ~r_cmd_full & ~rst;
    assign w_cmd_wptr_nxt = r_cmd_wptr + PW'(w_cmd_push);
    assign w_cmd_rptr_nxt = r_cmd_rptr + PW'(w_cmd_pop);

    always_ff @(posedge clk) begin
        if (w_cmd_push)
            r_cmd_mem[r_cmd_wptr[AW-1:0]] <= cmd_din;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cmd_wptr  <= '0;
            r_cmd_rptr  <= '0;
            r_cmd_full  <= 1'b0;
            r_cmd_empty <= 1'b1;
            r_overflow  <= 1'b0;
        end else begin
            r_cmd_wptr  <= w_cmd_wptr_nxt;
            r_cmd_rptr  <= w_cmd_rptr_nxt;
            r_cmd_empty <= (w_cmd_wptr_nxt == w_cmd_rptr_nxt);
            r_cmd_full  <= (w_cmd_wptr_nxt[AW] != w_cmd_rptr_nxt[AW]) &&
                           (w_cmd_wptr_nxt[AW-1:0] == w_cmd_rptr_nxt[AW-1:0]);
            // Judged on the pre-edge full flag: a same-cycle pop does not rescue it.
            if (cmd_wr_en && r_cmd_full)
                r_overflow <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Response FIFO
    // ------------------------------------------------------------------
    logic [31:0]   r_rsp_mem [DEPTH];
    logic [PW-1:0] r_rsp_wptr, r_rsp_rptr;
    logic [PW-1:0] w_rsp_wptr_nxt, w_rsp_rptr_nxt;
    logic          r_rsp_full, r_rsp_empty;
    logic          w_rsp_wr, w_rsp_pop;
    logic [31:0]   r_rsp_dout, w_rsp_head_nxt;

    assign w_rsp_wr       = w_rsp_push & ~r_rsp_full & ~rst;
    assign w_rsp_pop      = rsp_rd_en & ~r_rsp_empty & ~rst;
    assign w_rsp_wptr_nxt = r_rsp_wptr + PW'(w_rsp_wr);
    assign w_rsp_rptr_nxt = r_rsp_rptr + PW'(w_rsp_pop);

    // Registered head word. When the FIFO drains, the last value is held. When
    // the new head is the slot being written this edge, bypass the write data.
    always_comb begin
        w_rsp_head_nxt = r_rsp_dout;
        if (w_rsp_rptr_nxt != w_rsp_wptr_nxt) begin
            if (w_rsp_wr && (w_rsp_rptr_nxt == r_rsp_wptr))
                w_rsp_head_nxt = spi_dout;
            else
                w_rsp_head_nxt = r_rsp_mem[w_rsp_rptr_nxt[AW-1:0]];
        end
    end

    always_ff @(posedge clk) begin
        if (w_rsp_wr)
            r_rsp_mem[r_rsp_wptr[AW-1:0]] <= spi_dout;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rsp_wptr  <= '0;
            r_rsp_rptr  <= '0;
            r_rsp_full  <= 1'b0;
            r_rsp_empty <= 1'b1;
            r_rsp_dout  <= '0;
        end else begin
            r_rsp_wptr  <= w_rsp_wptr_nxt;
            r_rsp_rptr  <= w_rsp_rptr_nxt;
            r_rsp_empty <= (w_rsp_wptr_nxt == w_rsp_rptr_nxt);
            r_rsp_full  <= (w_rsp_wptr_nxt[AW] != w_rsp_rptr_nxt[AW]) &&
                           (w_rsp_wptr_nxt[AW-1:0] == w_rsp_rptr_nxt[AW-1:0]);
            r_rsp_dout  <= w_rsp_head_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Sequencer FSM
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_cmd_pop   = 1'b0;
        w_rsp_push  = 1'b0;
        case (r_state)
            IDLE: begin
                // A command is only launched when its response has a slot.
                if (!r_cmd_empty && !r_rsp_full) begin
                    w_cmd_pop   = 1'b1;
                    w_state_nxt = TRIG;
                    w_cnt_nxt   = '0;
                end
            end
            TRIG: begin
                if (r_cnt == TRIG_LAST) begin
                    w_state_nxt = GAP;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end
            GAP: begin
                if (r_cnt == GAP_LAST) begin
                    w_state_nxt = CAPTURE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end
            CAPTURE: begin
                w_rsp_push  = 1'b1;
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    logic        r_trig;
    logic [31:0] r_spi_din;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_trig    <= 1'b0;
            r_spi_din <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_trig  <= (r_state == TRIG);
            if (w_cmd_pop)
                r_spi_din <= r_cmd_mem[r_cmd_rptr[AW-1:0]];
        end
    end

    assign cmd_full    = r_cmd_full;
    assign cmd_empty   = r_cmd_empty;
    assign overflow    = r_overflow;
    assign rsp_empty   = r_rsp_empty;
    assign rsp_dout    = r_rsp_dout;
    assign spi_trigger = r_trig;
    assign spi_din     = r_spi_din;
    assign busy        = (r_state != IDLE);

endmodule

// File: tb/tb_spi_cmd_sequencer.sv
// Self-checking bench for spi_cmd_sequencer. A stimulus process queues the
// expected issued commands and responses; a monitor process compares them as
// the DUT raises triggers and as responses are popped. The SPI engine is
// modelled as a fixed function of spi_din.
module tb_spi_cmd_sequencer;

    localparam int DEPTH = 4;
    localparam int TC    = 24;
    localparam int GC    = 5;
    localparam int CMD_T = TC + GC + 6;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_wr_en = 1'b0;
    logic [31:0] cmd_din = '0;
    logic        rsp_rd_en = 1'b0;
    logic        cmd_full, cmd_empty, spi_trigger, rsp_empty, busy, overflow;
    logic [31:0] spi_din, spi_dout, rsp_dout;

    always #5 clk = ~clk;

    spi_cmd_sequencer #(.DEPTH(DEPTH), .TRIG_CYCLES(TC), .GAP_CYCLES(GC)) dut (
        .clk(clk), .rst(rst), .cmd_wr_en(cmd_wr_en), .cmd_din(cmd_din),
        .cmd_full(cmd_full), .cmd_empty(cmd_empty), .spi_din(spi_din),
        .spi_trigger(spi_trigger), .spi_dout(spi_dout), .rsp_rd_en(rsp_rd_en),
        .rsp_dout(rsp_dout), .rsp_empty(rsp_empty), .busy(busy), .overflow(overflow)
    );

    int          vectors = 0;
    int          miscompares = 0;
    logic [31:0] exp_cmd_q[$];
    logic [31:0] exp_rsp_q[$];
    int          wr_cnt = 0;
    int          rd_cnt = 0;
    logic [31:0] last_rd = '0;
    logic        fixed_en = 1'b0;

    function automatic logic [31:0] eng(input logic [31:0] x);
        return {x[15:0], x[31:16]} ^ 32'h3C3C_A5A5;
    endfunction

    assign spi_dout = fixed_en ? 32'h0000_BEEF : eng(spi_din);

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // ---------------- monitor ----------------
    int   cyc = 0;
    int   hi_len = 0;
    int   last_fall = -1;
    logic prev_trig = 1'b0;
    logic abort = 1'b1;

    always @(negedge clk) begin
        logic [31:0] e;
        cyc++;
        if (!rst) begin
            if (rsp_rd_en) begin
                if (!rsp_empty) begin
                    if (exp_rsp_q.size() == 0) begin
                        vectors++; miscompares++;
                        $display("FAIL rsp_unexpected: got %h expected no response", rsp_dout);
                    end else begin
                        e = exp_rsp_q.pop_front();
                        chk("rsp_dout", rsp_dout, e);
                        last_rd = e;
                        rd_cnt++;
                    end
                end else begin
                    chk("rsp_hold_on_empty_read", rsp_dout, last_rd);
                end
            end
            if (spi_trigger && !prev_trig) begin
                if (exp_cmd_q.size() == 0) begin
                    vectors++; miscompares++;
                    $display("FAIL trig_unexpected: got spi_din %h expected no command", spi_din);
                end else begin
                    chk("spi_din", spi_din, exp_cmd_q.pop_front());
                end
                if (last_fall >= 0) begin
                    vectors++;
                    if (cyc - last_fall < GC + 2) begin
                        miscompares++;
                        $display("FAIL trig_gap: got %0d low cycles expected >= %0d", cyc - last_fall, GC + 2);
                    end
                end
                hi_len = 0;
                abort  = 1'b0;
            end
            if (spi_trigger) hi_len++;
            if (!spi_trigger && prev_trig) begin
                last_fall = cyc;
                if (!abort) chk("trig_len", hi_len, TC);
            end
        end else begin
            abort     = 1'b1;
            last_fall = -1;
        end
        prev_trig = spi_trigger;
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic push_cmd(input logic [31:0] c, input bit accept);
        cmd_wr_en = 1'b1;
        cmd_din   = c;
        if (accept) begin
            exp_cmd_q.push_back(c);
            exp_rsp_q.push_back(fixed_en ? 32'h0000_BEEF : eng(c));
            wr_cnt++;
        end
        tick();
        cmd_wr_en = 1'b0;
    endtask

    task automatic drain(input int bound);
        tick();
        for (int i = 0; i < bound && rd_cnt != wr_cnt; i++) begin
            rsp_rd_en = !rsp_empty;
            tick();
        end
        rsp_rd_en = 1'b0;
        chk("drain_count", rd_cnt, wr_cnt);
    endtask

    task automatic wait_trig(input int bound);
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (spi_trigger) break;
        end
        chk("trigger_seen", spi_trigger, 1'b1);
    endtask

    initial begin
        // Reset with active inputs that must be ignored
        rst = 1'b1; cmd_wr_en = 1'b1; cmd_din = 32'hDEAD_0001; rsp_rd_en = 1'b1;
        repeat (3) @(posedge clk);
        #1; rst = 1'b0; cmd_wr_en = 1'b0; rsp_rd_en = 1'b0;
        @(negedge clk);
        chk("rst_cmd_empty", cmd_empty, 1'b1);
        chk("rst_cmd_full", cmd_full, 1'b0);
        chk("rst_rsp_empty", rsp_empty, 1'b1);
        chk("rst_trigger", spi_trigger, 1'b0);
        chk("rst_spi_din", spi_din, 32'h0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_overflow", overflow, 1'b0);
        chk("rst_rsp_dout", rsp_dout, 32'h0);

        // Single command with latency checks
        tick();
        fixed_en = 1'b1;
        push_cmd(32'hA50F_F0F8, 1'b1);
        for (int k = 0; k <= 4 + TC + GC; k++) begin
            @(negedge clk);
            if (k == 1) chk("lat_trig_n1", spi_trigger, 1'b0);
            if (k == 2) chk("lat_trig_n2", spi_trigger, 1'b1);
            if (k == 2) chk("single_spi_din", spi_din, 32'hA50F_F0F8);
            if (k == 2 + TC + GC) chk("lat_rsp_empty_before", rsp_empty, 1'b1);
            if (k == 3 + TC + GC) chk("lat_rsp_empty_after", rsp_empty, 1'b0);
            if (k == 4 + TC + GC) chk("single_busy_done", busy, 1'b0);
        end
        drain(20);
        fixed_en = 1'b0;

        // Three back-to-back commands
        for (int i = 0; i < 3; i++) push_cmd($urandom, 1'b1);
        drain(3 * CMD_T + 40);

        // Pre-fill responses, then overfill commands while FSM is blocked
        for (int i = 0; i < DEPTH; i++) push_cmd($urandom, 1'b1);
        repeat (DEPTH * CMD_T + 10) tick();
        for (int i = 0; i < DEPTH; i++) push_cmd($urandom, 1'b1);
        @(negedge clk);
        chk("fill_cmd_full", cmd_full, 1'b1);
        chk("fill_overflow_pre", overflow, 1'b0);
        push_cmd($urandom, 1'b0);
        @(negedge clk);
        chk("fill_overflow", overflow, 1'b1);
        chk("fill_cmd_full_kept", cmd_full, 1'b1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_trigger", spi_trigger, 1'b0);
            chk("stall_busy", busy, 1'b0);
        end
        tick();
        rsp_rd_en = 1'b1;
        tick();
        rsp_rd_en = 1'b0;
        wait_trig(20);
        drain(2 * DEPTH * CMD_T + 60);

        // Randomized traffic, never enough outstanding work to overfill
        tick();
        for (int c = 0; c < 1500; c++) begin
            cmd_wr_en = 1'b0;
            if ($urandom_range(0, 3) == 0 && (wr_cnt - rd_cnt) < DEPTH) begin
                cmd_din   = $urandom;
                cmd_wr_en = 1'b1;
                exp_cmd_q.push_back(cmd_din);
                exp_rsp_q.push_back(eng(cmd_din));
                wr_cnt++;
            end
            rsp_rd_en = ($urandom_range(0, 2) == 0);
            tick();
        end
        cmd_wr_en = 1'b0;
        rsp_rd_en = 1'b0;
        drain(2 * DEPTH * CMD_T + 60);

        // Read while empty: nothing changes
        rsp_rd_en = 1'b1;
        tick();
        rsp_rd_en = 1'b0;
        @(negedge clk);
        chk("empty_read_rsp_empty", rsp_empty, 1'b1);
        chk("empty_read_rsp_dout", rsp_dout, last_rd);

        // Reset in the middle of TRIG with another command pending
        tick();
        push_cmd($urandom, 1'b1);
        wait_trig(10);
        push_cmd($urandom, 1'b1);
        repeat (7) tick();
        rst = 1'b1; cmd_wr_en = 1'b1; cmd_din = 32'h1234_5678; rsp_rd_en = 1'b1;
        tick();
        rst = 1'b0; cmd_wr_en = 1'b0; rsp_rd_en = 1'b0;
        exp_cmd_q.delete();
        exp_rsp_q.delete();
        wr_cnt = 0; rd_cnt = 0; last_rd = '0;
        @(negedge clk);
        chk("midtrig_trigger", spi_trigger, 1'b0);
        chk("midtrig_rsp_empty", rsp_empty, 1'b1);
        chk("midtrig_cmd_empty", cmd_empty, 1'b1);
        chk("midtrig_overflow", overflow, 1'b0);
        chk("midtrig_busy", busy, 1'b0);
        chk("midtrig_spi_din", spi_din, 32'h0);
        repeat (TC + GC + 4) begin
            @(negedge clk);
            chk("midtrig_no_rsp", rsp_empty, 1'b1);
        end

        // Operation resumes after reset
        tick();
        push_cmd($urandom, 1'b1);
        drain(CMD_T + 40);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/spi_cmd_sequencer.md
SPI_CMD_SEQUENCER -- requirements
Module: spi_cmd_sequencer

Interface
REQ-001 SHALL have parameter DEPTH, default 8, command and response FIFO depth in words (power of 2, min 2).
REQ-002 SHALL have parameter TRIG_CYCLES, default 1700, number of clk cycles spi_trigger is held high per command (min 1).
REQ-003 SHALL have parameter GAP_CYCLES, default 16, number of idle clk cycles after trigger falls before capture (min 1).
REQ-004 SHALL have port clk  input  1  single system clock; all logic on rising edge.
REQ-005 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have port cmd_wr_en  input  1  push cmd_din into command FIFO.
REQ-007 SHALL have port cmd_din  input  32  command word {DATA[15:0], 6'b0, CPOL, CPHA, TARGET[7:0]}, passed through unmodified.
REQ-008 SHALL have port cmd_full  output  1  command FIFO holds DEPTH words.
REQ-009 SHALL have port cmd_empty  output  1  command FIFO holds 0 words.
REQ-010 SHALL have port spi_din  output  32  command word presented to the downstream SPI engine DIN.
REQ-011 SHALL have port spi_trigger  output  1  level trigger to the downstream SPI engine.
REQ-012 SHALL have port spi_dout  input  32  deserialized word returned by the SPI engine.
REQ-013 SHALL have port rsp_rd_en  input  1  pop response FIFO.
REQ-014 SHALL have port rsp_dout  output  32  head of response FIFO (first-word-fall-through).
REQ-015 SHALL have port rsp_empty  output  1  response FIFO holds 0 words.
REQ-016 SHALL have port busy  output  1  FSM not in IDLE.
REQ-017 SHALL have port overflow  output  1  sticky: a cmd write was dropped.

Function
REQ-018 SHALL implement FSM states IDLE, TRIG, GAP, CAPTURE.
REQ-019 IDLE SHALL, when command FIFO non-empty and response FIFO not full, pop one word, register it onto spi_din, and go to TRIG on the same edge.
REQ-020 IDLE SHALL stay in IDLE while response FIFO full, even if commands pending.
REQ-021 TRIG SHALL hold spi_trigger=1 for exactly TRIG_CYCLES cycles, then go to GAP.
REQ-022 GAP SHALL hold spi_trigger=0 for exactly GAP_CYCLES cycles, then go to CAPTURE.
REQ-023 CAPTURE SHALL push spi_dout (sampled that cycle) into response FIFO and return to IDLE after one cycle.
REQ-024 spi_trigger SHALL be a registered output, high only in TRIG; spi_din SHALL remain stable from pop until next pop.
REQ-025 Back-to-back commands SHALL have spi_trigger low for at least GAP_CYCLES+2 cycles between pulses.
REQ-026 Latency: with FSM idle and FIFOs empty, cmd_wr_en at edge N SHALL cause spi_trigger high after edge N+2; rsp_empty SHALL fall after edge N+3+TRIG_CYCLES+GAP_CYCLES.
REQ-027 cmd_full/cmd_empty/rsp_empty SHALL be registered and reflect occupancy after each edge.
REQ-028 cmd write when cmd_full (pre-edge value) SHALL be dropped and set overflow, even if a pop occurs same cycle.
REQ-029 Simultaneous cmd write and FSM pop when not full SHALL both take effect; occupancy unchanged.
REQ-030 rsp_rd_en when rsp_empty SHALL be ignored; rsp_dout holds last value.
REQ-031 Simultaneous rsp push and pop SHALL both take effect; pop when empty with push SHALL not pop.
REQ-032 FIFO pointers SHALL be log2(DEPTH)+1 bits wide, wrap modulo 2*DEPTH, full when MSBs differ and low bits equal.
REQ-033 TRIG/GAP counter SHALL be wide enough for max(TRIG_CYCLES,GAP_CYCLES) without wrap.

Reset
REQ-034 rst SHALL, on the next edge, force IDLE, spi_trigger=0, spi_din=0, busy=0, overflow=0, both FIFOs empty (cmd_empty=1, cmd_full=0, rsp_empty=1), rsp_dout=0, counter=0.
REQ-035 rst asserted mid-TRIG or mid-GAP SHALL drop spi_trigger on that edge and discard the in-flight command without pushing a response.
REQ-036 Inputs during rst SHALL be ignored.

Verification
REQ-037 Single command: write 32'hA50FF0F8, spi_dout=32'h0000BEEF -> spi_din=32'hA50FF0F8, trigger high exactly TRIG_CYCLES cycles, rsp_dout=32'h0000BEEF, busy returns 0.
REQ-038 Fill: write DEPTH+1 commands while rst held low and FSM blocked (response FIFO pre-filled) -> cmd_full=1 after DEPTH, overflow=1, last word never issued.
REQ-039 Back-to-back: 3 commands queued -> 3 trigger pulses, each TRIG_CYCLES long, gaps >= GAP_CYCLES+2, responses in order.
REQ-040 Backpressure: DEPTH responses unread -> FSM stalls in IDLE, spi_trigger=0; one rsp_rd_en -> next command issues.
REQ-041 Reset mid-TRIG: rst at cycle 10 of TRIG -> spi_trigger=0 next edge, rsp_empty=1, cmd_empty=1, overflow=0.
REQ-042 Empty read: rsp_rd_en with rsp_empty=1 -> no state change, rsp_dout unchanged.
